// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Brief   : Shared opcodes, state encodings and control-field encodings for
//           the multicycle MIPS main control unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] S_BASE = 4'd0;

  typedef enum logic [3:0] {
    S_FETCH  = S_BASE + 4'd0,
    S_DECODE = S_BASE + 4'd1,
    S_MEMADR = S_BASE + 4'd2,
    S_MEMRD  = S_BASE + 4'd3,
    S_MEMWB  = S_BASE + 4'd4,
    S_MEMWR  = S_BASE + 4'd5,
    S_EXEC   = S_BASE + 4'd6,
    S_ALUWB  = S_BASE + 4'd7,
    S_BEQ    = S_BASE + 4'd8,
    S_JUMP   = S_BASE + 4'd9,
    S_ADDIEX = S_BASE + 4'd10,
    S_ADDIWB = S_BASE + 4'd11,
    S_BNE    = S_BASE + 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_legal_op = 1'b1;
`ifdef CTRL_BNE_EN
      OP_BNE:                                        is_legal_op = 1'b1;
`endif
      default:                                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ============================================================================
// Module  : mc_ctrl_decode
// Brief   : Moore decode of FSM state (plus opcode in DECODE) into the control
//           word. Optional BNE state enabled by macro CTRL_BNE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_op,
  output ctrl_t           o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut regardless of opcode.
        o_ctrl.alu_src_b  = SRCB_IMM_SH2;
        o_ctrl.illegal_op = ~is_legal_op(i_op);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef CTRL_BNE_EN
      S_BNE: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.branch_ne     = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ============================================================================
// Module  : mc_control_unit
// Brief   : Main control FSM of the multicycle MIPS CPU. Optional BNE support
//           enabled by macro CTRL_BNE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int         OP_W     = 6,
  parameter logic [3:0] FETCH_ST = 4'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] Op,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            BranchNe,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            IRWrite,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUOp,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            InstrDone,
  output logic            IllegalOp
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_dec;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= state_t'(FETCH_ST);
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef CTRL_BNE_EN
          OP_BNE:       w_next = S_BNE;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .i_state (r_state),
    .i_op    (Op),
    .o_ctrl  (w_dec)
  );

  // Gating with rst keeps a store in flight from completing during abort.
  assign w_ctrl = rst ? '0 : w_dec;

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign BranchNe    = w_ctrl.branch_ne;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign IRWrite     = w_ctrl.ir_write;
  assign PCSource    = w_ctrl.pc_source;
  assign ALUOp       = w_ctrl.alu_op;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign RegWrite    = w_ctrl.reg_write;
  assign RegDst      = w_ctrl.reg_dst;
  assign InstrDone   = w_ctrl.instr_done;
  assign IllegalOp   = w_ctrl.illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// Module  : tb_mc_control_unit
// Brief   : Directed self-checking bench for mc_control_unit (honours
//           CTRL_BNE_EN for the opcode 0x05 step).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       bne;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       irw;
    logic [1:0] pcs;
    logic [1:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       rw;
    logic       rd;
    logic       done;
    logic       ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = 6'h00;

  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, InstrDone, IllegalOp;
  logic [1:0] PCSource, ALUOp, ALUSrcB;

  int errors = 0;
  int checks = 0;

  mc_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .Op          (op),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .BranchNe    (BranchNe),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .InstrDone   (InstrDone),
    .IllegalOp   (IllegalOp)
  );

  always #5 clk = ~clk;

  obs_t obs;
  assign obs = '{pcw: PCWrite, pcwc: PCWriteCond, bne: BranchNe, iord: IorD,
                 mrd: MemRead, mwr: MemWrite, m2r: MemtoReg, irw: IRWrite,
                 pcs: PCSource, aop: ALUOp, sa: ALUSrcA, sb: ALUSrcB,
                 rw: RegWrite, rd: RegDst, done: InstrDone, ill: IllegalOp};

  // Hand-written expected control words for each state.
  localparam obs_t E_ZERO   = '0;
  localparam obs_t E_FETCH  = '{pcw: 1'b1, mrd: 1'b1, irw: 1'b1, sb: 2'b01, default: '0};
  localparam obs_t E_DECODE = '{sb: 2'b11, default: '0};
  localparam obs_t E_ILL    = '{sb: 2'b11, ill: 1'b1, default: '0};
  localparam obs_t E_MEMADR = '{sa: 1'b1, sb: 2'b10, default: '0};
  localparam obs_t E_MEMRD  = '{mrd: 1'b1, iord: 1'b1, default: '0};
  localparam obs_t E_MEMWB  = '{rw: 1'b1, m2r: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_MEMWR  = '{mwr: 1'b1, iord: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_EXEC   = '{sa: 1'b1, aop: 2'b10, default: '0};
  localparam obs_t E_ALUWB  = '{rw: 1'b1, rd: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_BEQ    = '{sa: 1'b1, aop: 2'b01, pcwc: 1'b1, pcs: 2'b01,
                                done: 1'b1, default: '0};
  localparam obs_t E_BNE    = '{sa: 1'b1, aop: 2'b01, pcwc: 1'b1, pcs: 2'b01,
                                bne: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_JUMP   = '{pcw: 1'b1, pcs: 2'b10, done: 1'b1, default: '0};
  localparam obs_t E_ADDIEX = '{sa: 1'b1, sb: 2'b10, default: '0};
  localparam obs_t E_ADDIWB = '{rw: 1'b1, done: 1'b1, default: '0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held for 3 cycles
    rst = 1'b1;
    op  = 6'h00;
    tick(); chk("rst_c1", E_ZERO);
    tick(); chk("rst_c2", E_ZERO);
    tick(); chk("rst_c3", E_ZERO);
    rst = 1'b0;
    #1;
    chk("release_fetch", E_FETCH);

    // lw: 0,1,2,3,4 then back to 0; Op change in S3 must be ignored
    op = 6'h23;
    tick(); chk("lw_decode", E_DECODE);
    tick(); chk("lw_memadr", E_MEMADR);
    tick(); chk("lw_memrd", E_MEMRD);
    op = 6'h2B;
    #1;
    chk("lw_memrd_opchg", E_MEMRD);
    tick(); chk("lw_memwb", E_MEMWB);
    tick(); chk("lw_fetch", E_FETCH);

    // sw: 0,1,2,5
    tick(); chk("sw_decode", E_DECODE);
    tick(); chk("sw_memadr", E_MEMADR);
    tick(); chk("sw_memwr", E_MEMWR);
    tick(); chk("sw_fetch", E_FETCH);

    // beq: 3 cycles
    op = 6'h04;
    tick(); chk("beq_decode", E_DECODE);
    tick(); chk("beq_s8", E_BEQ);
    tick(); chk("beq_fetch", E_FETCH);

    // j: 3 cycles
    op = 6'h02;
    tick(); chk("j_decode", E_DECODE);
    tick(); chk("j_s9", E_JUMP);
    tick(); chk("j_fetch", E_FETCH);

    // illegal opcode: IllegalOp pulse in DECODE, then FETCH
    op = 6'h3F;
    tick(); chk("ill_decode", E_ILL);
    tick(); chk("ill_fetch", E_FETCH);

    // opcode 0x05 depends on build option
    op = 6'h05;
`ifdef CTRL_BNE_EN
    tick(); chk("bne_decode", E_DECODE);
    tick(); chk("bne_s12", E_BNE);
    tick(); chk("bne_fetch", E_FETCH);
`else
    tick(); chk("bne_illegal", E_ILL);
    tick(); chk("bne_ill_fetch", E_FETCH);
`endif

    // addi: 0,1,10,11
    op = 6'h08;
    tick(); chk("addi_decode", E_DECODE);
    tick(); chk("addi_ex", E_ADDIEX);
    tick(); chk("addi_wb", E_ADDIWB);
    tick(); chk("addi_fetch", E_FETCH);

    // R-type aborted by reset in S6
    op = 6'h00;
    tick(); chk("r_decode", E_DECODE);
    tick(); chk("r_exec", E_EXEC);
    #2;
    rst = 1'b1;
    #1;
    chk("r_abort_zero", E_ZERO);
    tick(); chk("r_abort_hold", E_ZERO);
    rst = 1'b0;
    #1;
    chk("r_abort_fetch", E_FETCH);
    tick(); chk("r2_decode", E_DECODE);
    tick(); chk("r2_exec", E_EXEC);
    tick(); chk("r2_aluwb", E_ALUWB);
    tick(); chk("r2_fetch", E_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
